// File: rtl/uart_receiver.sv
// UART receive stage: 8N1 LSB-first, 16x oversampled, valid/ready holding register, framing/overrun pulses.
// Define UART_RX_MAJORITY_EN to take each bit as the 2-of-3 vote of samples 6/7/8 (decision moves to 8).
module uart_receiver #(
  parameter int unsigned BAUD_RATE  = 1156000,
  parameter int unsigned CLOCK_FREQ = 75000000,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                  r_clk,
  input  logic                  r_rst,
  input  logic                  rx_in,
  input  logic                  rx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rx_busy,
  output logic                  frame_err,
  output logic                  overrun_err
);
  localparam int unsigned TICK_RATE  = BAUD_RATE * OVERSAMPLE;
  localparam int unsigned DIV_CALC   = (CLOCK_FREQ + TICK_RATE / 2) / TICK_RATE;
  localparam int unsigned SAMPLE_DIV = (DIV_CALC > 1) ? DIV_CALC : 1;
  localparam int unsigned DIV_W      = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned CNT_W      = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned IDX_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
`ifdef UART_RX_MAJORITY_EN
  localparam int unsigned DECIDE     = OVERSAMPLE / 2;
`else
  localparam int unsigned DECIDE     = OVERSAMPLE / 2 - 1;
`endif

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e                state_q, state_d;
  logic                  sync1_q, sync2_q, prev_q;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  ferr_q, ferr_d;
  logic                  ovr_q, ovr_d;
  logic                  tick_c, decide_c, wrap_c, fall_c, bit_c;

  // Two-flop synchroniser plus a delayed copy for falling-edge detection
  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign fall_c   = prev_q & ~sync2_q;
  assign tick_c   = (state_q != IDLE) && (div_q == DIV_W'(SAMPLE_DIV - 1));
  assign decide_c = tick_c && (cnt_q == CNT_W'(DECIDE));
  assign wrap_c   = tick_c && (cnt_q == CNT_W'(OVERSAMPLE - 1));

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] maj_q, maj_d;

  // Hold the two samples preceding the decision tick for the vote
  always_comb begin
    maj_d = maj_q;
    if (tick_c && (cnt_q == CNT_W'(DECIDE - 2))) maj_d[0] = sync2_q;
    if (tick_c && (cnt_q == CNT_W'(DECIDE - 1))) maj_d[1] = sync2_q;
  end

  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) maj_q <= 2'b11;
    else        maj_q <= maj_d;
  end

  assign bit_c = (maj_q[0] & maj_q[1]) | (maj_q[0] & sync2_q) | (maj_q[1] & sync2_q);
`else
  assign bit_c = sync2_q;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q & ~rx_ready;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    if (state_q == IDLE || tick_c) div_d = '0;
    else                           div_d = DIV_W'(div_q + 1'b1);
    if (tick_c) cnt_d = CNT_W'(cnt_q + 1'b1);

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (fall_c) state_d = START;
      end
      START: begin
        if (decide_c && bit_c) begin
          state_d = IDLE;
        end else if (wrap_c) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (decide_c) shift_d = {bit_c, shift_q[DATA_WIDTH-1:1]};
        if (wrap_c) begin
          if (idx_q == IDX_W'(DATA_WIDTH - 1)) state_d = STOP;
          else                                 idx_d   = IDX_W'(idx_q + 1'b1);
        end
      end
      STOP: begin
        // Leave half a bit early so the next start edge is never missed
        if (decide_c) begin
          state_d = IDLE;
          if (bit_c) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            ovr_d   = valid_q & ~rx_ready;
          end else begin
            ferr_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge r_clk or negedge r_rst) begin
    if (!r_rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign rx_busy     = busy_q;
  assign frame_err   = ferr_q;
  assign overrun_err = ovr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: frame-level event schedule model checked every cycle, directed and random frames.
`timescale 1ns/1ps
module tb_uart_receiver;
  localparam int unsigned DW       = 8;
  localparam int unsigned BIT_CLKS = 64;
`ifdef UART_RX_MAJORITY_EN
  localparam int unsigned DEC_EXTRA = 4;
  localparam bit          MAJ       = 1'b1;
`else
  localparam int unsigned DEC_EXTRA = 0;
  localparam bit          MAJ       = 1'b0;
`endif
  // Edge seen 3 clocks after the line falls; stop centre is 9.5 bits (608 clocks) later
  localparam int unsigned T_BUSY  = 3;
  localparam int unsigned T_STOP  = 3 + 9 * BIT_CLKS + BIT_CLKS / 2 + DEC_EXTRA;
  localparam int unsigned T_FALSE = 3 + BIT_CLKS / 2 + DEC_EXTRA;
  localparam int EV_BUSY = 0, EV_LOAD = 1, EV_FERR = 2, EV_OFF = 3;

  typedef struct {
    int unsigned   due;
    int            kind;
    logic [DW-1:0] data;
  } ev_t;

  logic          r_clk = 1'b0;
  logic          r_rst, rx_in, rx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid, rx_busy, frame_err, overrun_err;

  ev_t           sched[$];
  int unsigned   cyc = 0;
  int            total = 0, bad = 0;
  logic          m_valid = 1'b0, m_busy = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0;
  logic [DW-1:0] m_data = '0;
  logic          ready_prev = 1'b0, valid_seen = 1'b0, rand_ready = 1'b0;
  int unsigned   last_rise = 0;
  int            ferr_cnt = 0, ovr_cnt = 0;

  uart_receiver dut (
    .r_clk(r_clk), .r_rst(r_rst), .rx_in(rx_in), .rx_ready(rx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_busy(rx_busy),
    .frame_err(frame_err), .overrun_err(overrun_err)
  );

  always #6.667 r_clk = ~r_clk;
  always @(posedge r_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: apply scheduled frame outcomes, then compare all outputs
  always @(negedge r_clk) begin : cmp
    logic          ld;
    logic [DW-1:0] ld_data;
    ld = 1'b0;
    ld_data = '0;
    if (!r_rst) begin
      sched.delete();
      m_valid = 1'b0; m_data = '0; m_busy = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    end else begin
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
      for (int i = int'(sched.size()) - 1; i >= 0; i--) begin
        if (sched[i].due == cyc) begin
          case (sched[i].kind)
            EV_BUSY: m_busy = 1'b1;
            EV_LOAD: begin m_busy = 1'b0; ld = 1'b1; ld_data = sched[i].data; end
            EV_FERR: begin m_busy = 1'b0; m_ferr = 1'b1; end
            default: m_busy = 1'b0;
          endcase
          sched.delete(i);
        end
      end
      if (ld) begin
        m_ovr   = m_valid && !ready_prev;
        m_valid = 1'b1;
        m_data  = ld_data;
      end else if (ready_prev) begin
        m_valid = 1'b0;
      end
    end
    check("outputs{valid,busy,ferr,ovr,data}",
          32'({rx_valid, rx_busy, frame_err, overrun_err, rx_data}),
          32'({m_valid, m_busy, m_ferr, m_ovr, m_data}));
    if (rx_valid && !valid_seen) last_rise = cyc;
    valid_seen = rx_valid;
    if (frame_err) ferr_cnt++;
    if (overrun_err) ovr_cnt++;
    ready_prev = rx_ready;
  end

  always @(posedge r_clk) begin
    if (rand_ready) begin
      #1;
      rx_ready = ($urandom_range(0, 3) == 0);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge r_clk);
      #1;
    end
  endtask

  task automatic sched_frame(input int kind, input logic [DW-1:0] d);
    sched.push_back(ev_t'{cyc + T_BUSY, EV_BUSY, '0});
    sched.push_back(ev_t'{cyc + ((kind == EV_OFF) ? T_FALSE : T_STOP), kind, d});
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    idle(1);
    rx_ready = 1'b0;
  endtask

  // Clock-aligned frame at 64 clocks/bit; optional 4-clock inversion centred on sample 7 of each data bit
  task automatic send_frame(input logic [DW-1:0] d, input logic stop, input logic glitch,
                            input logic [DW-1:0] exp_d);
    logic [9:0] fr;
    int         b, off;
    fr = {stop, d, 1'b0};
    sched_frame(stop ? EV_LOAD : EV_FERR, exp_d);
    for (int c = 0; c < 10 * BIT_CLKS; c++) begin
      b   = c / BIT_CLKS;
      off = c % BIT_CLKS;
      rx_in = fr[b] ^ (glitch && b >= 1 && b <= 8 && off >= 31 && off <= 34);
      idle(1);
    end
  endtask

  // Frame with a free-running bit period in ns, start edge aligned to the clock
  task automatic send_async(input logic [DW-1:0] d, input real bit_ns);
    logic [9:0] fr;
    fr = {1'b1, d, 1'b0};
    sched_frame(EV_LOAD, d);
    for (int i = 0; i < 10; i++) begin
      rx_in = fr[i];
      #(bit_ns);
    end
    @(posedge r_clk);
    #1;
  endtask

  initial begin : main
    int unsigned   e0;
    int            o0, f0;
    logic [DW-1:0] d;
    real           rates[3];
    rates = '{860.0, 877.2, 842.8};
    r_rst = 1'b1; rx_in = 1'b1; rx_ready = 1'b0;
    #1 r_rst = 1'b0;
    idle(5);
    check("reset_outputs", 32'({rx_valid, rx_busy, frame_err, overrun_err, rx_data}), 32'h0);
    r_rst = 1'b1;
    idle(10);

    e0 = cyc;
    send_frame(8'hA5, 1'b1, 1'b0, 8'hA5);
    check("basic_latency", last_rise - e0, MAJ ? 32'd615 : 32'd611);
    check("basic_data", 32'(rx_data), 32'hA5);
    check("basic_valid", 32'(rx_valid), 32'h1);
    consume();
    check("basic_ready_clears", 32'(rx_valid), 32'h0);

    foreach (rates[k]) begin
      send_async(8'h3C, rates[k]);
      idle(3);
      check("rate_data", 32'(rx_data), 32'h3C);
      check("rate_valid", 32'(rx_valid), 32'h1);
      consume();
    end

    o0 = ovr_cnt;
    send_frame(8'h00, 1'b1, 1'b0, 8'h00);
    send_frame(8'hFF, 1'b1, 1'b0, 8'hFF);
    idle(5);
    check("overrun_pulses", 32'(ovr_cnt - o0), 32'd1);
    check("overrun_data", 32'(rx_data), 32'hFF);
    check("overrun_valid", 32'(rx_valid), 32'h1);
    consume();
    o0 = ovr_cnt;
    fork
      begin
        send_frame(8'h00, 1'b1, 1'b0, 8'h00);
        send_frame(8'hFF, 1'b1, 1'b0, 8'hFF);
      end
      begin
        idle(10 * BIT_CLKS + T_STOP - 1);
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
      end
    join
    idle(5);
    check("ready_on_load_no_overrun", 32'(ovr_cnt - o0), 32'd0);
    check("ready_on_load_data", 32'(rx_data), 32'hFF);
    check("ready_on_load_valid", 32'(rx_valid), 32'h1);
    consume();

    f0 = ferr_cnt;
    send_frame(8'h55, 1'b0, 1'b0, 8'h55);
    idle(5);
    check("frame_err_pulses", 32'(ferr_cnt - f0), 32'd1);
    check("frame_err_no_valid", 32'(rx_valid), 32'h0);
    idle(2000);
    check("held_low_no_busy", 32'(rx_busy), 32'h0);
    check("held_low_no_retrigger", 32'(ferr_cnt - f0), 32'd1);
    rx_in = 1'b1;
    idle(50);
    send_frame(8'h81, 1'b1, 1'b0, 8'h81);
    check("after_low_data", 32'(rx_data), 32'h81);

    consume();
    sched_frame(EV_OFF, '0);
    rx_in = 1'b0;
    idle(20);
    rx_in = 1'b1;
    idle(100);
    check("glitch_no_valid", 32'(rx_valid), 32'h0);
    check("glitch_busy_cleared", 32'(rx_busy), 32'h0);

    fork
      send_frame(8'hF0, 1'b1, 1'b0, 8'hF0);
      begin
        idle(5 * BIT_CLKS + 20);
        r_rst = 1'b0;
        #1;
        check("midreset_outputs", 32'({rx_valid, rx_busy, frame_err, overrun_err, rx_data}), 32'h0);
        idle(3);
        r_rst = 1'b1;
      end
    join
    idle(20);
    send_frame(8'h12, 1'b1, 1'b0, 8'h12);
    check("after_reset_data", 32'(rx_data), 32'h12);
    consume();

    send_frame(8'h69, 1'b1, 1'b1, MAJ ? 8'h69 : 8'h96);
    check("sample_glitch_data", 32'(rx_data), MAJ ? 32'h69 : 32'h96);
    consume();

    rand_ready = 1'b1;
    repeat (12) begin
      d = DW'($urandom);
      if ($urandom_range(0, 1) == 1) send_frame(d, 1'b1, 1'b0, d);
      else                           send_async(d, 843.0 + real'($urandom_range(0, 34)));
      idle(int'($urandom_range(0, 30)));
    end
    rand_ready = 1'b0;
    idle(5);
    rx_ready = 1'b0;
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
